// File: rtl/cnt_pkg.sv
// Shared types and constants for the burst tick generator
// and the 4-bit counter it drives.
package cnt_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int NUM_W_DEF = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cnt_prescaler.sv
// Tick prescaler: counts 0..load-1 and flags when the
// value it moves to is the terminal one.
module cnt_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] load,
  output logic             tc
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] nxt;
  logic [DIV_W-1:0] last;

  // next count and look-ahead terminal strobe
  always_comb begin
    last = load - DIV_W'(1);
    nxt  = count;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = (count == last) ? '0 : count + DIV_W'(1);
    tc = (clr | en) & (nxt == last);
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= nxt;
  end

endmodule

// File: rtl/cnt_pulse_gen.sv
// Burst tick generator: NUM cnt pulses spaced DIV clocks
// apart, with start/busy/done/abort control.
module cnt_pulse_gen
  import cnt_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [NUM_W-1:0] num,
  input  logic             abort,
  output logic             cnt,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_l_nxt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] pre_load;
  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] rem_nxt;
  logic             cnt_nxt;
  logic             start_ok;
  logic             pre_en;
  logic             tc;
  logic             tick;

  cnt_prescaler #(
    .DIV_W (DIV_W)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .en   (pre_en),
    .load (pre_load),
    .tc   (tc)
  );

  // next-state, tick and remaining-count logic
  always_comb begin
    state_nxt = state;
    div_l_nxt = div_l;
    rem_nxt   = rem;
    cnt_nxt   = 1'b0;
    tick      = 1'b0;
    start_ok  = start & ~abort & (state != ST_RUN);
    div_eff   = (div == '0) ? DIV_W'(1) : div;
    pre_load  = start_ok ? div_eff : div_l;
    pre_en    = (state == ST_RUN);
    unique case (state)
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          tick    = tc & (rem != '0);
          cnt_nxt = tick;
          if (tick)
            rem_nxt = rem - NUM_W'(1);
          if (cnt && rem == '0)
            state_nxt = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start_ok) begin
          div_l_nxt = div_eff;
          tick      = tc & (num != '0);
          cnt_nxt   = tick;
          rem_nxt   = tick ? num - NUM_W'(1) : num;
          state_nxt = (num == '0) ? ST_DONE : ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state, latched divisor, remaining count and cnt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      div_l <= '0;
      rem   <= '0;
      cnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      div_l <= div_l_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // status decode from the state register
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_cnt_pulse_gen.sv
// Self-checking bench for cnt_pulse_gen: behavioural burst
// model, directed scenarios and randomized traffic.
module tb_cnt_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] div = '0;
  logic [3:0] num = '0;
  logic       abort = 1'b0;
  logic       cnt;
  logic       busy;
  logic       done;
  logic [3:0] ctr;

  int n_pass = 0;
  int n_total = 0;

  // model: 0 idle, 1 run, 2 done
  int mode = 0;
  int c = 0;
  int dl = 1;
  int nm = 0;
  int mcount = 0;
  bit e_cnt = 0;
  bit e_busy = 0;
  bit e_done = 0;

  // observation since the last accepted start
  int rel = 0;
  longint mask = 0;
  int done_at = -1;

  cnt_pulse_gen #(
    .DIV_W (8),
    .NUM_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .div   (div),
    .num   (num),
    .abort (abort),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // downstream 4-bit counter driven by cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ctr <= '0;
    else if (cnt)
      ctr <= ctr + 4'd1;
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_total++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mode = 0; c = 0; mcount = 0;
    e_cnt = 0; e_busy = 0; e_done = 0;
    rel = 0; mask = 0; done_at = -1;
  endtask

  task automatic cmp_all();
    chk("cnt", cnt, e_cnt);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("counter", ctr, mcount);
  endtask

  task automatic step(input bit s, input bit a,
                      input int d, input int n);
    bit acc;
    start = s; abort = a;
    div = d[7:0]; num = n[3:0];
    @(posedge clk);
    mcount = (mcount + int'(e_cnt)) % 16;
    acc = s && !a && mode != 1;
    if (mode == 1 && a) begin
      mode = 0;
    end else if (acc) begin
      dl = (d == 0) ? 1 : d;
      nm = n; c = 1;
      mode = (n == 0) ? 2 : 1;
      rel = 1; mask = 0; done_at = -1;
    end else if (mode == 1) begin
      c++;
      if (c > nm * dl) mode = 2;
    end else begin
      mode = 0;
    end
    if (!acc) rel++;
    e_cnt = (mode == 1) && (c % dl == 0);
    e_busy = (mode == 1);
    e_done = (mode == 2);
    #1;
    cmp_all();
    if (cnt && rel < 60) mask |= (64'd1 << rel);
    if (done) done_at = rel;
    start = 0; abort = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic basic_burst(input string tag);
    step(1, 0, 3, 4);
    idle(14);
    chk({tag, " mask"}, mask, 64'h1248);
    chk({tag, " done_at"}, done_at, 13);
    chk({tag, " ctr"}, ctr, 4);
  endtask

  initial begin
    model_reset();
    #12;
    cmp_all();
    @(negedge clk);
    rst = 1'b0;

    basic_burst("basic");

    pulse_reset();
    step(1, 0, 5, 0);
    idle(3);
    chk("zero mask", mask, 0);
    chk("zero done_at", done_at, 1);
    chk("zero ctr", ctr, 0);

    pulse_reset();
    step(1, 0, 0, 5);
    idle(5);
    chk("div0 mask", mask, 64'h3E);
    chk("div0 done_at", done_at, 6);
    chk("div0 done now", done, 1);
    step(1, 0, 2, 1);
    idle(3);
    chk("b2b mask", mask, 64'h4);
    chk("b2b done_at", done_at, 3);
    chk("b2b ctr", ctr, 6);

    pulse_reset();
    step(1, 0, 2, 8);
    idle(2);
    step(1, 0, 2, 1);
    idle(3);
    step(0, 1, 0, 0);
    chk("abort busy", busy, 0);
    idle(6);
    chk("abort mask", mask, 64'h54);
    chk("abort done_at", done_at, -1);
    chk("abort ctr", ctr, 3);

    pulse_reset();
    step(1, 0, 1, 10);
    idle(4);
    #3;
    rst = 1'b1;
    #1;
    chk("arst cnt", cnt, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    model_reset();
    #1;
    rst = 1'b0;
    basic_burst("post-arst");

    pulse_reset();
    step(1, 0, 1, 15);
    idle(16);
    chk("max mask", mask, 64'hFFFE);
    chk("max done_at", done_at, 16);
    chk("max ctr", ctr, 15);

    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 5),
           $urandom_range(0, 15));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cnt_pulse_gen.md
Name: cnt_pulse_gen

Overview:
- Programmable burst tick generator; sits directly upstream of the 4-bit synchronous T-flip-flop counter and drives its cnt enable.
- On a start request it emits exactly NUM single-cycle cnt pulses, spaced DIV clocks apart, then reports completion.
- The downstream counter (reset released, starting at 0) therefore ends at value NUM (mod 16).
- Provides the start/busy/done/abort control handshake used by the sequencing logic above the counter.

Parameters:
- DIV_W, 8, width of the tick-spacing divisor input.
- NUM_W, 4, width of the pulse-count input; matches the 4-bit counter.

Ports:
- clk  in  1  single system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; accepted only when busy=0.
- div  in  DIV_W  clocks between pulses; sampled on start acceptance; 0 is treated as 1.
- num  in  NUM_W  number of pulses; sampled on start acceptance.
- abort  in  1  terminate the running burst with no done pulse.
- cnt  out  1  enable to the counter; registered, one-cycle high per tick.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after the last tick.

Behaviour:
- Reset: asynchronous on rst=1. State goes to IDLE; cnt, busy, done, prescaler, remaining-count and latched div/num registers all go to 0. Reset mid-burst terminates it silently.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Start acceptance: start=1 and abort=0 at edge E0, in state IDLE or DONE.
  - div_l is latched as max(div,1); rem is latched as num; the prescaler is cleared.
  - If num=0, the next state is DONE (done high in cycle 1, no cnt). Otherwise the next state is RUN.
- Start in RUN is ignored. It is neither queued nor re-latched, and changes to div/num during RUN have no effect.
- Tick timing: number the clock periods after E0 as cycle 1, 2, ...
  - cnt=1 in cycles k*div_l for k=1..num, and 0 in all other cycles.
  - Mechanism: the prescaler counts 0..div_l-1; its terminal value sets the cnt register and decrements rem.
- Completion: the edge ending the last cnt cycle moves RUN to DONE. done=1 and busy=0 in cycle num*div_l+1, then the state returns to IDLE.
  - If start is accepted in the DONE cycle, the next state is RUN, with done high for that one cycle only.
- Abort: abort=1 at an edge in RUN moves to IDLE. cnt and busy clear on that edge; there is no done and no further ticks. Abort in IDLE/DONE is a no-op.
- Priority at an edge: rst > abort > start. abort+start together means the start is rejected.
- div_l=1 gives a contiguous num-cycle cnt high. The prescaler never wraps past div_l-1.
- num=15 is the maximum and drives the counter from 0 to 15; there is no overflow handling here.
- Arithmetic: the prescaler is DIV_W bits and rem is NUM_W bits, all unsigned. rem never decrements below 0.

Decomposition:
- Shared package cnt_pkg holds:
  - the state enum {ST_IDLE, ST_RUN, ST_DONE};
  - DIV_W/NUM_W defaults;
  - the constant CNT_W=4 shared with the counter.
- Sub-module cnt_prescaler (DIV_W): clear, enable, load value; it outputs a terminal-count strobe.
- The FSM, rem counter and output registers stay in cnt_pulse_gen.

Test Plan:
- Basic burst: reset, then start with div=3, num=4 → cnt high in cycles 3,6,9,12; done in cycle 13; busy high in cycles 1-12; downstream counter reads 4'b0100.
- Zero count: num=0, div=5 → no cnt; done=1 in cycle 1; busy never high; counter stays 0.
- div=0 and back-to-back start:
  - start with div=0, num=5 → cnt high in cycles 1-5, done in cycle 6.
  - A second start (div=2, num=1) during the done cycle → cnt in cycle 2 after it, and a second done pulse.
- Abort and ignored start:
  - start with div=2, num=8; a start with num=1 in cycle 3 is ignored.
  - abort in cycle 7 → cnt seen only in cycles 2, 4, 6; busy falls after the abort edge; no done; counter reads 3.
- Async reset mid-burst: rst pulsed between edges in cycle 5 of a div=1, num=10 burst → cnt, busy and done go to 0 immediately without a clock edge; a subsequent start behaves like the basic burst.
- Max count: div=1, num=15 → 15 contiguous cnt cycles, counter reaches 4'b1111, done in cycle 16.
